// File: rtl/alu_pkg.sv
// Shared ALU constants and request type used by the ALU share arbiter and its bench.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 2;

    localparam logic [OPW-1:0] ALU_ADD  = 2'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 2'd1;
    localparam logic [OPW-1:0] ALU_NAND = 2'd2;
    localparam logic [OPW-1:0] ALU_NOR  = 2'd3;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator; on a tie the requester that did not win last is chosen.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant    = '0;
        grant[0] = enable && valid[0] && (!valid[1] || last_grant);
        grant[1] = enable && valid[1] && (!valid[0] || !last_grant);
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the EX issue port (0) and the debug port (1) with a one-entry
// registered response buffer tagged by requester id.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } req_t;

    logic [1:0]       grant;
    logic             can_accept;
    req_t             sel;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_id_q,    rsp_id_d;
    logic             last_grant_q, last_grant_d;

    // A full buffer being drained this cycle can take a new op: 1 op/cycle throughput.
    assign can_accept = !rsp_valid_q || rsp_ready;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .enable     (can_accept),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        sel    = '0;
        sel.op = OPW'(ALU_ADD);
        if (grant[0]) begin
            sel = '{a: req0_a, b: req0_b, op: req0_op};
        end else if (grant[1]) begin
            sel = '{a: req1_a, b: req1_b, op: req1_op};
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (|grant) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = alu_out;
            rsp_id_d     = grant[1];
            last_grant_d = grant[1];
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign alu_a      = sel.a;
    assign alu_b      = sel.b;
    assign alu_op     = sel.op;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = rsp_valid_q || req0_valid || req1_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: expected responses are queued at grant time and
// popped by an independent monitor when the DUT presents/consumes them.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [31:0] rsp_data;

    alu_share_arb #(.WIDTH(32), .OPW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the pipeline ALU.
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_NAND: alu_out = ~(alu_a & alu_b);
            default:  alu_out = ~(alu_a | alu_b);
        endcase
    end

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          checks = 0;
    int          errors = 0;
    int          m_last = 1;
    bit          in_rst = 1'b1;
    bit          fresh = 1'b0;
    bit          pv[2];
    logic [31:0] pa[2], pb[2];
    logic [1:0]  po[2];
    bit          rdy;

    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        pv[i] = 1'b1;
        pa[i] = a;
        pb[i] = b;
        po[i] = op;
    endtask

    task automatic rand_req(input int i);
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom();
        if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
        if ($urandom_range(0, 7) == 0) b = '0;
        set_req(i, a, b, 2'($urandom_range(0, 3)));
    endtask

    // One clock: drive after the edge, then compare arbitration against the model before the next edge.
    task automatic step();
        int g;
        bit full, can;
        @(posedge clk);
        #1;
        req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
        req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
        rsp_ready  = rdy;
        #6;
        full = (sb.size() != 0);
        can  = !full || rdy;
        g    = -1;
        if (can) begin
            if (pv[0] && pv[1]) g = (m_last == 0) ? 1 : 0;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
        end
        chk("req0_ready", 64'(req0_ready), 64'(g == 0));
        chk("req1_ready", 64'(req1_ready), 64'(g == 1));
        chk("busy", 64'(busy), 64'(full || pv[0] || pv[1]));
        chk("rsp_valid", 64'(rsp_valid), 64'(full));
        if (g >= 0) begin
            chk("alu_a", 64'(alu_a), 64'(pa[g]));
            chk("alu_b", 64'(alu_b), 64'(pb[g]));
            chk("alu_op", 64'(alu_op), 64'(po[g]));
            sb.push_back('{id: g[0], data: alu_ref(pa[g], pb[g], po[g])});
            m_last = g;
            pv[g]  = 1'b0;
        end else begin
            chk("alu_idle", 64'({alu_a, alu_b, alu_op}), 64'(0));
        end
        if (req0_ready) glog.push_back(0);
        if (req1_ready) glog.push_back(1);
        fresh = (g >= 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        sb.delete();
        m_last = 1;
        fresh  = 1'b0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    // Monitor: compare the presented response each cycle, pop when consumed.
    initial begin
        forever begin
            @(posedge clk);
            #8;
            if (!in_rst) begin
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected got=%0h id=%0d exp=none", rsp_data, rsp_id);
                    end else begin
                        chk("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                        if (rsp_ready) void'(sb.pop_front());
                    end
                end else begin
                    checks++;
                    if (sb.size() > (fresh ? 1 : 0)) begin
                        errors++;
                        $display("FAIL rsp_missing got=rsp_valid0 exp=%0d pending", sb.size());
                    end
                end
                fresh = 1'b0;
            end
        end
    end

    initial begin
        pv[0] = 0; pv[1] = 0; pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; po[0] = '0; po[1] = '0;
        rdy = 1'b1;
        do_reset();

        // Single requester add.
        set_req(0, 32'd5, 32'd3, ALU_ADD);
        step();
        step();
        chk("t1_data", 64'(rsp_data), 64'(32'd8));
        chk("t1_id", 64'(rsp_id), 64'(0));

        // Simultaneous requests after reset: 0 first, then 1.
        do_reset();
        set_req(0, 32'd10, 32'd4, ALU_SUB);
        set_req(1, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_NAND);
        step();
        step();
        chk("t2_data0", 64'(rsp_data), 64'(32'd6));
        chk("t2_id0", 64'(rsp_id), 64'(0));
        step();
        chk("t2_data1", 64'(rsp_data), 64'(32'h0FFF_0FFF));
        chk("t2_id1", 64'(rsp_id), 64'(1));

        // Backpressure holds req1 off and keeps rsp stable.
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        step();
        rdy = 1'b0;
        set_req(1, 32'd0, 32'd0, ALU_NOR);
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_ready1", 64'(req1_ready), 64'(0));
            chk("t3_hold_data", 64'(rsp_data), 64'(32'd3));
        end
        rdy = 1'b1;
        step();
        chk("t3_accept", 64'(req1_ready), 64'(1));
        step();
        chk("t3_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));
        chk("t3_id", 64'(rsp_id), 64'(1));

        // Modular wrap-around.
        set_req(0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
        step();
        step();
        chk("t4_add_wrap", 64'(rsp_data), 64'(0));
        set_req(1, 32'd0, 32'd1, ALU_SUB);
        step();
        step();
        chk("t4_sub_wrap", 64'(rsp_data), 64'(32'hFFFF_FFFF));

        // Continuous contention: strict alternation starting with 0.
        glog.delete();
        rand_req(0);
        rand_req(1);
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            if (!pv[0]) rand_req(0);
            if (!pv[1]) rand_req(1);
        end
        chk("t5_grants", 64'(glog.size()), 64'(20));
        for (int unsigned i = 0; i < glog.size(); i++)
            chk("t5_alternate", 64'(glog[i]), 64'(i % 2));

        // Randomized traffic with random backpressure.
        for (int unsigned i = 0; i < 300; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++)
                if (!pv[r] && $urandom_range(0, 2) != 0) rand_req(r);
            step();
        end

        // Reset with a response in flight; requester 0 preferred afterwards.
        rdy = 1'b1;
        rand_req(0);
        rand_req(1);
        step();
        rdy = 1'b0;
        step();
        chk("t7_pre_valid", 64'(rsp_valid), 64'(1));
        do_reset();
        rdy = 1'b1;
        rand_req(0);
        rand_req(1);
        step();
        chk("t7_first_grant0", 64'(req0_ready), 64'(1));

        // Drain.
        pv[0] = 0;
        pv[1] = 0;
        for (int unsigned i = 0; i < 10 && (sb.size() != 0 || rsp_valid); i++) step();
        step();
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 2-operand ALU (ops: add, sub, nand, nor) between two requesters.
- Requester 0 is the pipeline EX issue; requester 1 is the secondary/debug port.
- Round-robin arbitration with valid/ready handshakes. Drives the ALU operand/opcode inputs combinationally and captures the ALU result into a one-entry registered response buffer tagged with the requester ID.
- Sits between the ID/EX issue logic and the EX/MEM writeback path.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 2, opcode width; encoding 0=add, 1=sub, 2=nand, 3=nor.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  OPW  requester 0 ALU opcode.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- req1_op  in  OPW  requester 1 ALU opcode.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_op  out  OPW  opcode to the ALU.
- alu_out  in  WIDTH  combinational result from the ALU.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  WIDTH  registered ALU result.
- rsp_id  out  1  requester that produced rsp_data.
- busy  out  1  rsp_valid OR any reqN_valid.

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (so requester 0 wins the first tie). Clears immediately, independent of clk.
- Buffer capacity: can_accept = !rsp_valid | rsp_ready. A full buffer that is drained in the same cycle accepts a new operation, giving full throughput of 1 op/cycle.
- Arbitration (combinational, only when can_accept=1):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - None valid or can_accept=0: no grant.
- Ready: reqN_ready = grantN. Ready depends on valid; requesters must not make valid depend on ready.
- ALU drive:
  - Granted: alu_a/alu_b/alu_op = granted requester's fields.
  - No grant: alu_a/alu_b/alu_op = 0 (op=add), keeping ALU inputs quiet.
- Capture: on a clock edge with a grant, rsp_data<=alu_out, rsp_id<=granted index, rsp_valid<=1, last_grant<=granted index.
- Drain: on a clock edge with rsp_valid & rsp_ready and no grant, rsp_valid<=0. rsp_data/rsp_id hold their last values.
- Latency: a request accepted in cycle N is visible on rsp_* in cycle N+1.
- Backpressure: rsp_valid=1 & rsp_ready=0 → no grant; both readys 0; rsp_* held stable.
- Requester protocol: once reqN_valid=1 it stays asserted with stable fields until reqN_ready=1. The bench checks this; RTL need not.
- last_grant updates only on an actual grant. A single-requester stream does not disturb the tie order seen by later contention.
- Arithmetic: WIDTH-bit modular add/sub performed in the ALU. The arbiter never alters the data; no overflow flag.
- Fairness: under continuous contention, grants alternate 0,1,0,1… Neither requester waits more than one accepted op.
- Reset mid-operation: any in-flight response is discarded (rsp_valid=0); arbitration restarts with requester 0 preferred.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and OPW constants.
  - opcode localparams ALU_ADD=0, ALU_SUB=1, ALU_NAND=2, ALU_NOR=3.
  - a request struct/typedef {a, b, op}.
- One natural sub-module: rr_arb2. It is a 2-way round-robin grant generator with inputs valid[1:0], enable, and last_grant state, and outputs a one-hot grant.
- The top level is the operand mux, response register and handshake glue, and instantiates the existing ALU only in the bench.

Test Plan:
- Reset, then req0 only: a=5, b=3, op=ADD, rsp_ready=1 → req0_ready=1 in cycle 0; cycle 1: rsp_valid=1, rsp_data=8, rsp_id=0.
- Simultaneous req0 (10-4, SUB) and req1 (0xF0F0F0F0 NAND 0xFF00FF00) held valid, rsp_ready=1:
  - cycle 0 grants 0 → rsp 6/id0;
  - cycle 1 grants 1 → rsp 0x0FFF0FFF/id1.
- Backpressure: rsp_ready=0 with rsp_valid=1 and req1 valid (0 NOR 0) → req1_ready=0 for 3 cycles, rsp_data stable. Then rsp_ready=1 → same-cycle accept; next cycle rsp_data=0xFFFFFFFF, id1.
- Wrap-around: req0 0xFFFFFFFF+1 → rsp_data=0; req1 0-1 SUB → rsp_data=0xFFFFFFFF.
- Continuous contention for 20 cycles, rsp_ready=1 → 20 responses, ids strictly alternate starting with 0; each result matches the reference model.
- Assert rst_n=0 mid-stream with rsp_valid=1 → rsp_valid drops asynchronously before the next clk edge. After release, with both valid, requester 0 is granted first.
